// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan path.
package display_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    localparam logic [1:0] DIG_THOUSANDS = 2'd0;
    localparam logic [1:0] DIG_HUNDREDS  = 2'd1;
    localparam logic [1:0] DIG_TENS      = 2'd2;
    localparam logic [1:0] DIG_ONES      = 2'd3;

    localparam int BCD_MAX = 9999;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to 4-digit BCD converter with sign/clamp capture.
import display_pkg::*;

module bin2bcd_seq #(
    parameter int DATA_W = 12,
    parameter bit SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [15:0]       bcd,
    output logic              neg,
    output logic              ovf
);

    conv_state_t       state_q, state_d;
    logic [DATA_W-1:0] bin_q;
    logic [15:0]       bcd_q;
    logic [4:0]        cnt_q;
    logic              neg_q, ovf_q;

    logic [DATA_W-1:0] mag, bin_load;
    logic              neg_c, ovf_c;

    // Negating as unsigned DATA_W bits maps the most negative code onto its true magnitude.
    always_comb begin
        mag   = din;
        neg_c = 1'b0;
        if (SIGNED && din[DATA_W-1]) begin
            mag   = ~din + 1'b1;
            neg_c = 1'b1;
        end
        ovf_c    = 32'(mag) > 32'(BCD_MAX);
        bin_load = ovf_c ? DATA_W'(BCD_MAX) : mag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = SHIFT;
            SHIFT: if (cnt_q == 5'd0) state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q <= bin_load;
                        bcd_q <= '0;
                        cnt_q <= 5'(DATA_W - 1);
                        neg_q <= neg_c;
                        ovf_q <= ovf_c;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {add3(bcd_q), bin_q} << 1;
                    if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign bcd  = bcd_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/display_scan_driver.sv
// Sample-to-BCD producer for the 4-digit display: converter, held result registers, digit scan.
import display_pkg::*;

module display_scan_driver #(
    parameter int DATA_W      = 12,
    parameter bit SIGNED      = 1'b1,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        thousands,
    output logic [3:0]        hundreds,
    output logic [3:0]        tens,
    output logic [3:0]        ones,
    output logic              neg,
    output logic              ovf,
    output logic [1:0]        digit_sel
);

    localparam int RW = $clog2(REFRESH_DIV);

    logic        conv_done, conv_neg, conv_ovf;
    logic [15:0] conv_bcd;
    logic [RW-1:0] refresh_q;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (data_valid),
        .din   (data_in),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .neg   (conv_neg),
        .ovf   (conv_ovf)
    );

    // Displayed result only moves on the converter's completion, so the scan never shows partial digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            thousands <= '0;
            hundreds  <= '0;
            tens      <= '0;
            ones      <= '0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= conv_done;
            if (conv_done) begin
                {thousands, hundreds, tens, ones} <= conv_bcd;
                neg <= conv_neg;
                ovf <= conv_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            digit_sel <= DIG_THOUSANDS;
        end else if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_q <= '0;
            digit_sel <= digit_sel + 2'd1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomised and directed checks of display_scan_driver in three width/sign configurations.
module tb_display_scan_driver;

    localparam int DW_OF [3] = '{12, 12, 16};
    localparam int SG_OF [3] = '{0, 1, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dv [3];
    logic [11:0] din_u12, din_s12;
    logic [15:0] din_u16;
    logic busy_a [3], done_a [3], neg_a [3], ovf_a [3];
    logic [3:0] th [3], hu [3], te [3], on [3];
    logic [1:0] sel [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    display_scan_driver #(.DATA_W(12), .SIGNED(1'b0), .REFRESH_DIV(4)) u_u12 (
        .clk(clk), .rst_n(rst_n), .data_valid(dv[0]), .data_in(din_u12),
        .busy(busy_a[0]), .done(done_a[0]), .thousands(th[0]), .hundreds(hu[0]),
        .tens(te[0]), .ones(on[0]), .neg(neg_a[0]), .ovf(ovf_a[0]), .digit_sel(sel[0]));

    display_scan_driver #(.DATA_W(12), .SIGNED(1'b1), .REFRESH_DIV(4)) u_s12 (
        .clk(clk), .rst_n(rst_n), .data_valid(dv[1]), .data_in(din_s12),
        .busy(busy_a[1]), .done(done_a[1]), .thousands(th[1]), .hundreds(hu[1]),
        .tens(te[1]), .ones(on[1]), .neg(neg_a[1]), .ovf(ovf_a[1]), .digit_sel(sel[1]));

    display_scan_driver #(.DATA_W(16), .SIGNED(1'b0), .REFRESH_DIV(4)) u_u16 (
        .clk(clk), .rst_n(rst_n), .data_valid(dv[2]), .data_in(din_u16),
        .busy(busy_a[2]), .done(done_a[2]), .thousands(th[2]), .hundreds(hu[2]),
        .tens(te[2]), .ones(on[2]), .neg(neg_a[2]), .ovf(ovf_a[2]), .digit_sel(sel[2]));

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    endtask

    function automatic int get_bcd(input int inst);
        return int'({th[inst], hu[inst], te[inst], on[inst]});
    endfunction

    // Reference: decimal digits of the (possibly negated, clamped) sample by plain arithmetic.
    function automatic void model(input int inst, input int val,
                                  output int bcd, output int n, output int o);
        int w, raw, mag;
        w   = DW_OF[inst];
        raw = val & ((1 << w) - 1);
        mag = raw;
        n   = 0;
        if (SG_OF[inst] != 0 && raw >= (1 << (w - 1))) begin
            mag = (1 << w) - raw;
            n   = 1;
        end
        o = (mag > 9999) ? 1 : 0;
        if (o != 0) mag = 9999;
        bcd = ((mag / 1000) << 12) | (((mag / 100) % 10) << 8) | (((mag / 10) % 10) << 4) | (mag % 10);
    endfunction

    task automatic drive(input int inst, input logic v, input int val);
        dv[inst] = v;
        case (inst)
            0: din_u12 = 12'(val);
            1: din_s12 = 12'(val);
            default: din_u16 = 16'(val);
        endcase
    endtask

    // Strobe val at cycle T and check busy/done/digits every cycle up to T+W+2.
    // extra_at > 0 injects a second strobe in that cycle offset, which must be ignored.
    task automatic convert(input int inst, input int val, input int extra_at, input int extra_val);
        int eb, en, eo, pb, w;
        w = DW_OF[inst];
        model(inst, val, eb, en, eo);
        pb = get_bcd(inst);
        @(posedge clk); #1;
        drive(inst, 1'b1, val);
        for (int k = 1; k <= w + 2; k++) begin
            @(posedge clk); #1;
            drive(inst, 1'b0, val);
            if (k == extra_at) drive(inst, 1'b1, extra_val);
            if (k < w + 2) begin
                chk("busy_during", busy_a[inst], 1);
                chk("done_early", done_a[inst], 0);
                if (k == w / 2) chk("digits_held", get_bcd(inst), pb);
            end else begin
                chk("busy_at_done", busy_a[inst], 0);
                chk("done_pulse", done_a[inst], 1);
                chk("digits", get_bcd(inst), eb);
                chk("neg", neg_a[inst], en);
                chk("ovf", ovf_a[inst], eo);
            end
        end
        @(posedge clk); #1;
        drive(inst, 1'b0, 0);
        chk("done_one_cycle", done_a[inst], 0);
    endtask

    task automatic check_quiet(input int inst, input int cycles, input int exp_bcd);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            chk("no_second_done", done_a[inst], 0);
            chk("idle_busy", busy_a[inst], 0);
        end
        chk("digits_kept", get_bcd(inst), exp_bcd);
    endtask

    task automatic check_reset_vals();
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", busy_a[i], 0);
            chk("rst_done", done_a[i], 0);
            chk("rst_digits", get_bcd(i), 0);
            chk("rst_neg", neg_a[i], 0);
            chk("rst_ovf", ovf_a[i], 0);
            chk("rst_sel", sel[i], 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) dv[i] = 1'b0;
        din_u12 = '0; din_s12 = '0; din_u16 = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        chk("sel_start", sel[0], 0);
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk); #1;
            chk("digit_sel", sel[0], (j / 4) % 4);
            chk("digit_sel_s16", sel[2], (j / 4) % 4);
        end

        convert(0, 1234, 0, 0);
        convert(0, 0, 0, 0);
        convert(0, 4095, 0, 0);
        convert(1, 12'hF38, 0, 0);
        convert(1, 12'h800, 0, 0);
        convert(1, 12'h7FF, 0, 0);
        convert(2, 50000, 0, 0);
        convert(2, 10, 0, 0);
        convert(2, 65535, 0, 0);
        convert(2, 9999, 0, 0);
        convert(2, 10000, 0, 0);

        convert(0, 1234, 3, 5678);
        check_quiet(0, 18, 16'h1234);
        convert(1, 12'hFFF, 13, 300);
        check_quiet(1, 18, 16'h0001);

        for (int i = 0; i < 30; i++) begin
            convert(int'($urandom_range(0, 2)), int'($urandom_range(0, 65535)), 0, 0);
        end

        convert(0, 1234, 0, 0);
        @(posedge clk); #1;
        drive(0, 1'b1, 4000);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, 4000);
        end
        chk("mid_busy", busy_a[0], 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        convert(0, 7, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
